// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and execute-stage FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} exec_state_e;

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from ifun and the CC flags.
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd,
  output logic       bad_ifun
);

  always_comb begin
    cnd      = 1'b0;
    bad_ifun = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (sf ^ of) | zf;
      C_L:      cnd = sf ^ of;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~(sf ^ of);
      C_G:      cnd = ~(sf ^ of) & ~zf;
      default:  bad_ifun = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_exec_stage.sv
// Registered Y86-64 execute stage: valE, cnd, CC register, valid/ready on both sides.
// Define EXEC_MUL_EN to add the iterative shift-add mulq (OPq ifun 4) and its FSM.
module y86_exec_stage
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int STACK_STEP = 8,
  parameter int MUL_BPC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [DATA_W-1:0] valC,
  input  logic              set_cc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] valE,
  output logic              cnd,
  output logic              err,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic              cond_cnd, cond_bad;
  logic [DATA_W-1:0] res;
  logic              cnd_d, err_d, of_d, cc_we, mul_start;
  logic              accept, out_free, load_std, mul_done;

  y86_cond_eval u_cond (
    .ifun     (ifun),
    .zf       (cc_zf),
    .sf       (cc_sf),
    .of       (cc_of),
    .cnd      (cond_cnd),
    .bad_ifun (cond_bad)
  );

  always_comb begin
    res       = '0;
    cnd_d     = 1'b0;
    err_d     = 1'b0;
    of_d      = 1'b0;
    cc_we     = 1'b0;
    mul_start = 1'b0;
    case (icode)
      I_CMOVXX: begin
        res   = valA;
        cnd_d = cond_cnd;
        err_d = cond_bad;
      end
      I_IRMOVQ:          res = valC;
      I_RMMOVQ, I_MRMOVQ: res = valB + valC;
      I_OPQ: begin
        case (ifun)
          ALU_ADD: begin
            res   = valB + valA;
            of_d  = (valA[DATA_W-1] == valB[DATA_W-1]) && (res[DATA_W-1] != valB[DATA_W-1]);
            cc_we = 1'b1;
          end
          ALU_SUB: begin
            res   = valB - valA;
            of_d  = (valA[DATA_W-1] != valB[DATA_W-1]) && (res[DATA_W-1] != valB[DATA_W-1]);
            cc_we = 1'b1;
          end
          ALU_AND: begin
            res   = valB & valA;
            cc_we = 1'b1;
          end
          ALU_XOR: begin
            res   = valB ^ valA;
            cc_we = 1'b1;
          end
`ifdef EXEC_MUL_EN
          ALU_MUL: mul_start = 1'b1;
`endif
          default: err_d = 1'b1;
        endcase
      end
      I_JXX: begin
        cnd_d = cond_cnd;
        err_d = cond_bad;
      end
      I_CALL, I_PUSHQ: res = valB - STEP;
      I_RET, I_POPQ:   res = valB + STEP;
      default: ;
    endcase
  end

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load_std = accept && !mul_start;

`ifdef EXEC_MUL_EN
  localparam int MUL_CYCLES = DATA_W / MUL_BPC;
  localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

  exec_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic              mul_cc_q;

  function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] mcand,
                                                 input logic [DATA_W-1:0] mplier);
    logic [DATA_W-1:0] sum;
    sum = acc;
    for (int k = 0; k < MUL_BPC; k++)
      if (mplier[k]) sum = sum + (mcand << k);
    return sum;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && mul_start) state_d = ST_MUL;
      ST_MUL:  if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Low DATA_W bits of an unsigned product equal the two's complement product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_cc_q <= 1'b0;
    end else if (accept && mul_start) begin
      cnt_q    <= CNT_W'(MUL_CYCLES);
      acc_q    <= '0;
      mcand_q  <= valB;
      mplier_q <= valA;
      mul_cc_q <= set_cc;
    end else if (state_q == ST_MUL) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      acc_q    <= mul_step(acc_q, mcand_q, mplier_q);
      mcand_q  <= mcand_q << MUL_BPC;
      mplier_q <= mplier_q >> MUL_BPC;
    end
  end

  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign mul_done = (state_q == ST_DONE);
`else
  assign in_ready = out_free;
  assign mul_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      valE      <= '0;
      cnd       <= 1'b0;
      err       <= 1'b0;
    end else if (mul_done) begin
`ifdef EXEC_MUL_EN
      out_valid <= 1'b1;
      valE      <= acc_q;
      cnd       <= 1'b0;
      err       <= 1'b0;
`endif
    end else if (load_std) begin
      out_valid <= 1'b1;
      valE      <= res;
      cnd       <= cnd_d;
      err       <= err_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cc_zf, cc_sf, cc_of} <= 3'b100;
    end else if (mul_done) begin
`ifdef EXEC_MUL_EN
      if (mul_cc_q) {cc_zf, cc_sf, cc_of} <= {acc_q == '0, acc_q[DATA_W-1], 1'b0};
`endif
    end else if (load_std && set_cc && cc_we) begin
      {cc_zf, cc_sf, cc_of} <= {res == '0, res[DATA_W-1], of_d};
    end
  end

endmodule

// File: tb/tb_y86_exec_stage.sv
// Self-checking bench for y86_exec_stage: vector table plus stall, mulq and reset sequences.
module tb_y86_exec_stage;
  import y86_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, set_cc, out_valid, out_ready;
  logic [3:0]   icode, ifun;
  logic [W-1:0] valA, valB, valC, valE;
  logic         cnd, err, cc_zf, cc_sf, cc_of;

  always #5 clk = ~clk;

  y86_exec_stage #(.DATA_W(W), .STACK_STEP(8), .MUL_BPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cnd(cnd), .err(err), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  typedef struct {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] a, b, c;
    logic         set_cc;
    logic [W-1:0] e_vale;
    logic         e_cnd;
    logic         e_err;
    logic [2:0]   e_cc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic sc, input logic [W-1:0] ev, input logic ec,
                              input logic ee, input logic [2:0] ecc);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.set_cc = sc;
    v.e_vale = ev; v.e_cnd = ec; v.e_err = ee; v.e_cc = ecc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    icode = v.icode; ifun = v.ifun; valA = v.a; valB = v.b; valC = v.c; set_cc = v.set_cc;
    in_valid = 1'b1;
  endtask

  task automatic issue(input vec_t v);
    int waitc;
    waitc = 0;
    drive(v);
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 200) begin
        n_checks++; n_fail++;
        $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain_queue_empty", W'(sb.size()), '0);
  endtask

  // Scoreboard pop on the handshake; CC sampled with the result it belongs to.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: got valE %h, required no result", valE);
      end else begin
        e = sb.pop_front();
        check("valE", valE, e.e_vale);
        check("cnd", W'(cnd), W'(e.e_cnd));
        check("err", W'(err), W'(e.e_err));
        check("cc", W'({cc_zf, cc_sf, cc_of}), W'(e.e_cc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t v;
    in_valid = 0; icode = 0; ifun = 0; valA = 0; valB = 0; valC = 0; set_cc = 0; out_ready = 1;

    vecs.push_back(mk(I_JXX, 4'd3, 0, 0, 0, 0, 0, 1, 0, 3'b100));
    vecs.push_back(mk(I_OPQ, 4'd0, 1, MAXP, 0, 1, MINN, 0, 0, 3'b011));
    vecs.push_back(mk(I_JXX, 4'd2, 0, 0, 0, 0, 0, 0, 0, 3'b011));
    vecs.push_back(mk(I_JXX, 4'd1, 0, 0, 0, 0, 0, 0, 0, 3'b011));
    vecs.push_back(mk(I_JXX, 4'd5, 0, 0, 0, 0, 0, 1, 0, 3'b011));
    vecs.push_back(mk(I_JXX, 4'd6, 0, 0, 0, 0, 0, 1, 0, 3'b011));
    vecs.push_back(mk(I_OPQ, 4'd1, 5, 5, 0, 0, 0, 0, 0, 3'b011));
    vecs.push_back(mk(I_OPQ, 4'd1, 5, 5, 0, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(I_JXX, 4'd4, 0, 0, 0, 0, 0, 0, 0, 3'b100));
    vecs.push_back(mk(I_JXX, 4'd0, 0, 0, 0, 0, 0, 1, 0, 3'b100));
    vecs.push_back(mk(I_OPQ, 4'd7, 1, 2, 0, 1, 0, 0, 1, 3'b100));
    vecs.push_back(mk(I_JXX, 4'd9, 0, 0, 0, 0, 0, 0, 1, 3'b100));
    vecs.push_back(mk(I_CMOVXX, 4'd0, 64'h1234, 64'h55, 0, 0, 64'h1234, 1, 0, 3'b100));
    vecs.push_back(mk(I_IRMOVQ, 4'd0, 0, 0, 64'hABCD, 0, 64'hABCD, 0, 0, 3'b100));
    vecs.push_back(mk(I_RMMOVQ, 4'd0, 0, 64'h1000, 64'h18, 0, 64'h1018, 0, 0, 3'b100));
    vecs.push_back(mk(I_MRMOVQ, 4'd0, 0, ONES, 2, 0, 1, 0, 0, 3'b100));
    vecs.push_back(mk(I_CALL, 4'd0, 0, 64'h100, 0, 0, 64'hF8, 0, 0, 3'b100));
    vecs.push_back(mk(I_RET, 4'd0, 0, 64'hF8, 0, 0, 64'h100, 0, 0, 3'b100));
    vecs.push_back(mk(I_POPQ, 4'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 4, 0, 0, 3'b100));
    vecs.push_back(mk(I_PUSHQ, 4'd0, 0, 4, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 3'b100));
    vecs.push_back(mk(I_NOP, 4'd0, 9, 9, 9, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(I_OPQ, 4'd2, 64'hFF00, 64'hF0F0, 0, 1, 64'hF000, 0, 0, 3'b000));
    vecs.push_back(mk(I_OPQ, 4'd3, 64'hAA, 64'hAA, 0, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(I_OPQ, 4'd1, 1, MINN, 0, 1, MAXP, 0, 0, 3'b001));
    vecs.push_back(mk(I_JXX, 4'd2, 0, 0, 0, 0, 0, 1, 0, 3'b001));
    vecs.push_back(mk(I_CMOVXX, 4'd6, 64'h77, 0, 0, 0, 64'h77, 0, 0, 3'b001));
`ifndef EXEC_MUL_EN
    vecs.push_back(mk(I_OPQ, 4'd4, 3, 7, 0, 1, 0, 0, 1, 3'b001));
`endif
    vecs.push_back(mk(I_OPQ, 4'd0, MINN, MINN, 0, 1, 0, 0, 0, 3'b101));
    vecs.push_back(mk(I_JXX, 4'd2, 0, 0, 0, 0, 0, 1, 0, 3'b101));
    vecs.push_back(mk(I_JXX, 4'd1, 0, 0, 0, 0, 0, 1, 0, 3'b101));
    vecs.push_back(mk(I_JXX, 4'd6, 0, 0, 0, 0, 0, 0, 0, 3'b101));
    vecs.push_back(mk(I_CMOVXX, 4'd7, 64'h5, 0, 0, 0, 64'h5, 0, 1, 3'b101));

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_valE", valE, 0);
    check("rst_cnd", W'(cnd), 0);
    check("rst_err", W'(err), 0);
    check("rst_cc", W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
    check("rst_in_ready", W'(in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Output held under backpressure; a waiting instruction must not be taken.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(mk(I_PUSHQ, 4'd0, 0, 64'h100, 0, 0, 64'hF8, 0, 0, 3'b101));
    v = mk(I_IRMOVQ, 4'd0, 0, 0, 64'h42, 0, 64'h42, 0, 0, 3'b101);
    drive(v);
    repeat (3) begin
      @(negedge clk);
      check("stall_out_valid", W'(out_valid), 1);
      check("stall_valE", valE, 64'hF8);
      check("stall_in_ready", W'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(v);
    drain();

`ifdef EXEC_MUL_EN
    begin
      int cyc;
      logic stalled_ok;
      issue(mk(I_OPQ, ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 7, 0, 1,
               64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 3'b010));
      cyc = 0;
      stalled_ok = 1'b1;
      while (!out_valid && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
        if (!out_valid && in_ready) stalled_ok = 1'b0;
      end
      check("mul_latency", W'(cyc), 65);
      check("mul_in_ready_low", W'(stalled_ok), 1);
      drain();

      issue(mk(I_OPQ, ALU_MUL, 3, 5, 0, 1, 15, 0, 0, 3'b000));
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mulrst_out_valid", W'(out_valid), 0);
      check("mulrst_cc", W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(mk(I_JXX, 4'd3, 0, 0, 0, 0, 0, 1, 0, 3'b100));
      repeat (70) @(posedge clk);
      #1;
      check("mulrst_no_late_result", W'(out_valid), 0);
      drain();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
